// File: rtl/manchester_serdes.sv
// Manchester serial transmitter/receiver (IEEE 802.3 polarity), MSB first, start symbol + stop gap.
// Define MANCHESTER_PARITY_EN to append an even-parity bit to every frame.
module manchester_serdes #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned HALF_BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  input  logic              rx_line,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err
);

  localparam int unsigned H = HALF_BIT_CYCLES;
`ifdef MANCHESTER_PARITY_EN
  localparam int unsigned NB = DATA_W + 1;
`else
  localparam int unsigned NB = DATA_W;
`endif
  localparam int unsigned TCW = $clog2(2 * H);
  localparam int unsigned BW  = $clog2(NB);
  localparam int unsigned PW  = $clog2(H);
  localparam int unsigned KW  = $clog2(2 * NB + 2);

  localparam logic [TCW-1:0] TC_HALF = TCW'(H - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(2 * H - 1);
  localparam logic [BW-1:0]  BI_LAST = BW'(NB - 1);
  localparam logic [PW-1:0]  PH_MID  = PW'(H / 2);
  localparam logic [PW-1:0]  PH_LAST = PW'(H - 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(2 * NB + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_GAP} tx_state_t;
  typedef enum logic {RX_IDLE, RX_FRAME} rx_state_t;

  tx_state_t       tx_state;
  logic [NB-1:0]   tx_shift;
  logic [NB-1:0]   tx_frame;
  logic [TCW-1:0]  tx_cnt;
  logic [BW-1:0]   tx_bit;

  always_comb begin
`ifdef MANCHESTER_PARITY_EN
    tx_frame = {tx_data, ^tx_data};
`else
    tx_frame = tx_data;
`endif
  end

  // tx_line is registered, so each edge loads the level of the half that starts next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_frame;
            tx_cnt   <= '0;
            tx_line  <= 1'b1;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == TC_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= ~tx_shift[NB-1];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + TCW'(1);
          end
        end
        TX_DATA: begin
          tx_cnt <= tx_cnt + TCW'(1);
          if (tx_cnt == TC_HALF) tx_line <= tx_shift[NB-1];
          if (tx_cnt == TC_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == BI_LAST) begin
              tx_line  <= 1'b0;
              tx_state <= TX_GAP;
            end else begin
              tx_bit   <= tx_bit + BW'(1);
              tx_shift <= {tx_shift[NB-2:0], 1'b0};
              tx_line  <= ~tx_shift[NB-2];
            end
          end
        end
        TX_GAP: begin
          if (tx_cnt == TC_LAST) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + TCW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t       rx_state;
  logic            rx_sync;
  logic            rx_s;
  logic            rx_s_prev;
  logic [PW-1:0]   rx_ph;
  logic [KW-1:0]   rx_k;
  logic            rx_first;
  logic            rx_viol;
  logic [NB-1:0]   rx_word;
  logic            viol_next;
  logic [NB-1:0]   word_next;
  logic            frame_ok;
  logic [DATA_W-1:0] word_data;

  always_comb begin
    viol_next = rx_viol | (rx_first == rx_s);
    word_next = {rx_word[NB-2:0], rx_s};
`ifdef MANCHESTER_PARITY_EN
    frame_ok  = !viol_next && !(^word_next);
    word_data = word_next[NB-1:1];
`else
    frame_ok  = !viol_next;
    word_data = word_next;
`endif
  end

  // rx_ph tracks the frame counter modulo H; the rising-edge cycle counts as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_sync   <= 1'b0;
      rx_s      <= 1'b0;
      rx_s_prev <= 1'b0;
      rx_ph     <= '0;
      rx_k      <= '0;
      rx_first  <= 1'b0;
      rx_viol   <= 1'b0;
      rx_word   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_sync   <= loopback ? tx_line : rx_line;
      rx_s      <= rx_sync;
      rx_s_prev <= rx_s;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s && !rx_s_prev) begin
            rx_ph    <= PW'(1);
            rx_k     <= '0;
            rx_viol  <= 1'b0;
            rx_state <= RX_FRAME;
          end
        end
        RX_FRAME: begin
          rx_ph <= (rx_ph == PH_LAST) ? '0 : rx_ph + PW'(1);
          if (rx_ph == PH_MID) begin
            rx_k <= rx_k + KW'(1);
            if (rx_k < KW'(2)) begin
              if (!rx_s) rx_state <= RX_IDLE;
            end else if (!rx_k[0]) begin
              rx_first <= rx_s;
            end else if (rx_k == K_LAST) begin
              rx_state <= RX_IDLE;
              if (frame_ok) begin
                rx_data  <= word_data;
                rx_valid <= 1'b1;
              end else begin
                rx_err <= 1'b1;
              end
            end else begin
              rx_viol <= viol_next;
              rx_word <= word_next;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_serdes.sv
// Self-checking bench for manchester_serdes: vector table, directed corner cases and
// randomized frames checked against a frame-level Manchester model.
`timescale 1ns/1ps
module tb_manchester_serdes;
  localparam int DW = 8;
  localparam int H  = 4;
`ifdef MANCHESTER_PARITY_EN
  localparam int NB = DW + 1;
  localparam bit LIT_OK = 1'b0;
`else
  localparam int NB = DW;
  localparam bit LIT_OK = 1'b1;
`endif
  localparam int L    = (NB + 2) * 2 * H;
  localparam int LMAX = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_line;
  logic          rx_line;
  logic          loopback;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_err;

  always #5 clk = ~clk;

  manchester_serdes #(.DATA_W(DW), .HALF_BIT_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_line(tx_line), .rx_line(rx_line), .loopback(loopback),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] rxq[$];
  int err_pulses = 0;
  int both_pulses = 0;
  logic [DW-1:0] last_good = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) rxq.push_back(rx_data);
      if (rx_err) err_pulses++;
      if (rx_valid && rx_err) both_pulses++;
    end
  end

  typedef struct {
    logic [DW-1:0]   data;
    logic [LMAX-1:0] wave;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string nm, input logic [LMAX-1:0] act, input logic [LMAX-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [DW-1:0] w, input int b);
    if (b < DW) return w[DW-1-b];
    return ^w;
  endfunction

  function automatic logic model_line(input logic [DW-1:0] w, input int j);
    int off;
    int b;
    if (j < 2 * H) return 1'b1;
    if (j >= (NB + 1) * 2 * H) return 1'b0;
    off = j - 2 * H;
    b = off / (2 * H);
    if ((off % (2 * H)) < H) return !frame_bit(w, b);
    return frame_bit(w, b);
  endfunction

  function automatic logic [LMAX-1:0] model_wave(input logic [DW-1:0] w);
    logic [LMAX-1:0] v = '0;
    for (int j = 0; j < L; j++) v[L-1-j] = model_line(w, j);
    return v;
  endfunction

  function automatic logic [2*NB+1:0] build_halves(input logic [DW-1:0] w);
    logic [2*NB+1:0] hv;
    hv[0] = 1'b1;
    hv[1] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      hv[2*b+2] = !frame_bit(w, b);
      hv[2*b+3] = frame_bit(w, b);
    end
    return hv;
  endfunction

  function automatic void model_rx(input logic [2*NB+1:0] hv, output logic ok, output logic [NB-1:0] bits);
    ok = hv[0] && hv[1];
    bits = '0;
    for (int i = 0; i < NB; i++) begin
      if (hv[2*i+2] == hv[2*i+3]) ok = 1'b0;
      bits[NB-1-i] = hv[2*i+3];
    end
    if (NB > DW && (^bits)) ok = 1'b0;
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    if (!tx_ready) check({nm, "_ready_timeout"}, tx_ready, 1);
  endtask

  task automatic send_and_check(input logic [DW-1:0] w, input bit use_lit,
                                input logic [LMAX-1:0] lit, input string nm);
    logic [LMAX-1:0] cap;
    bit rdy_seen;
    int q0;
    int e0;
    wait_ready(nm);
    q0 = rxq.size();
    e0 = err_pulses;
    tx_data = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    cap = '0;
    rdy_seen = 1'b0;
    for (int j = 0; j < L; j++) begin
      cap[L-1-j] = tx_line;
      if (tx_ready) rdy_seen = 1'b1;
      tx_data = DW'($urandom);
      tx_valid = (j < L - 1) ? 1'($urandom) : 1'b0;
      tick();
    end
    check({nm, "_wave"}, cap, model_wave(w));
    if (use_lit) check({nm, "_wave_lit"}, cap, lit);
    check({nm, "_busy"}, rdy_seen, 0);
    check({nm, "_ready_back"}, tx_ready, 1);
    repeat (4) tick();
    check({nm, "_rx_count"}, rxq.size() - q0, 1);
    if (rxq.size() > q0) check({nm, "_rx_data"}, rxq[$], w);
    check({nm, "_rx_err"}, err_pulses - e0, 0);
    last_good = w;
  endtask

  task automatic rx_frame(input logic [2*NB+1:0] hv, input string nm);
    logic ok;
    logic [NB-1:0] bits;
    int q0;
    int e0;
    model_rx(hv, ok, bits);
    q0 = rxq.size();
    e0 = err_pulses;
    for (int i = 0; i < 2 * NB + 2; i++) begin
      rx_line = hv[i];
      repeat (H) tick();
    end
    rx_line = 1'b0;
    repeat (2 * H + 4) tick();
    check({nm, "_valid_cnt"}, rxq.size() - q0, ok ? 1 : 0);
    check({nm, "_err_cnt"}, err_pulses - e0, ok ? 0 : 1);
    if (ok) last_good = bits[NB-1 -: DW];
    check({nm, "_rx_data"}, rx_data, last_good);
  endtask

  initial begin
    logic [2*NB+1:0] hv;
    int acc;
    int cyc;
    int acc_t[2];
    int q0;
    int e0;

    tbl[0].data = 8'hA5; tbl[0].wave = 80'hFF0FF00FF0F00FF00F00;
    tbl[1].data = 8'h80; tbl[1].wave = 80'hFF0FF0F0F0F0F0F0F000;
    tbl[2].data = 8'h3C; tbl[2].wave = 80'hFFF0F00F0F0F0FF0F000;
    tbl[3].data = 8'h00; tbl[3].wave = 80'hFFF0F0F0F0F0F0F0F000;

    tx_data = '0;
    tx_valid = 1'b0;
    rx_line = 1'b0;
    loopback = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_tx_line", tx_line, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_err", rx_err, 0);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++)
      send_and_check(tbl[i].data, LIT_OK, tbl[i].wave, $sformatf("vec%0d", i));

    // back-to-back with tx_valid held high
    wait_ready("b2b");
    q0 = rxq.size();
    tx_data = 8'h00;
    tx_valid = 1'b1;
    acc = 0;
    cyc = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    while (acc < 2 && cyc < 400) begin
      if (tx_ready) begin
        acc_t[acc] = cyc;
        acc++;
      end
      tick();
      cyc++;
      if (acc == 1) tx_data = 8'hFF;
    end
    tx_valid = 1'b0;
    check("b2b_accepts", acc, 2);
    check("b2b_spacing", acc_t[1] - acc_t[0], L + 1);
    repeat (L + 4) tick();
    check("b2b_rx_count", rxq.size() - q0, 2);
    if (rxq.size() >= q0 + 2) begin
      check("b2b_rx0", rxq[q0], 8'h00);
      check("b2b_rx1", rxq[q0+1], 8'hFF);
    end
    last_good = 8'hFF;

    // external line: good frame then a frame with word bit 3 high/high
    loopback = 1'b0;
    hv = build_halves(8'h3C);
    rx_frame(hv, "rx3c");
    hv[2*(DW-1-3)+2] = 1'b1;
    hv[2*(DW-1-3)+3] = 1'b1;
    rx_frame(hv, "rx3c_bad");

    // reset in the middle of a loopback frame
    loopback = 1'b1;
    wait_ready("rst");
    q0 = rxq.size();
    e0 = err_pulses;
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (29) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_line", tx_line, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 0);
    last_good = '0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    repeat (100) tick();
    check("midrst_no_valid", rxq.size() - q0, 0);
    check("midrst_no_err", err_pulses - e0, 0);
    send_and_check(8'hC3, 1'b0, '0, "after_rst");

    // glitches on the external line
    loopback = 1'b0;
    q0 = rxq.size();
    e0 = err_pulses;
    rx_line = 1'b1;
    tick();
    rx_line = 1'b0;
    repeat (10) tick();
    rx_line = 1'b1;
    repeat (6) tick();
    rx_line = 1'b0;
    repeat (40) tick();
    check("glitch_no_valid", rxq.size() - q0, 0);
    check("glitch_no_err", err_pulses - e0, 0);
    rx_frame(build_halves(8'h96), "after_glitch");

    // randomized loopback words
    loopback = 1'b1;
    for (int r = 0; r < 6; r++)
      send_and_check(DW'($urandom), 1'b0, '0, $sformatf("rnd_lb%0d", r));

    // randomized external frames, some with an equal-halves violation
    loopback = 1'b0;
    for (int r = 0; r < 8; r++) begin
      int b;
      hv = build_halves(DW'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, NB - 1);
        hv[2*b+2] = 1'($urandom);
        hv[2*b+3] = hv[2*b+2];
      end
      repeat ($urandom_range(0, 5)) tick();
      rx_frame(hv, $sformatf("rnd_rx%0d", r));
    end

    check("no_valid_err_overlap", both_pulses, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
